// File: rtl/count_dir_decoder_pkg.sv
// Shared types and constants for the up/down counter direction decoder.
package count_dir_decoder_pkg;

   // Decoder state
   typedef enum logic [1:0] {
      StIdle,
      StAcq,
      StLocked
   } state_e;

   // Classification of one observed sample against the previous one
   typedef enum logic [1:0] {
      ClsUp,
      ClsDn,
      ClsHold,
      ClsIllegal
   } step_cls_e;

   localparam logic MODE_UP = 1'b1;
   localparam logic MODE_DN = 1'b0;

   // Run counter is wide enough for the largest legal lock threshold (15)
   localparam int unsigned RUN_W = 4;

endpackage

// File: rtl/count_step_classify.sv
// Combinational classifier: compares a new counter value with the previous one.
module count_step_classify
   import count_dir_decoder_pkg::*;
#(
   parameter int unsigned WIDTH = 3
) (
   input  logic [WIDTH-1:0] prev_i,
   input  logic [WIDTH-1:0] q_i,
   output step_cls_e        cls_o,
   output logic             wrap_o
);

   localparam logic [WIDTH-1:0] One = {{(WIDTH-1){1'b0}}, 1'b1};

   logic [WIDTH-1:0] inc;
   logic [WIDTH-1:0] dec;

   assign inc = prev_i + One;
   assign dec = prev_i - One;

   // Hold is tested first; for WIDTH >= 2 the three legal cases never overlap
   always_comb begin
      cls_o  = ClsIllegal;
      wrap_o = 1'b0;
      if (q_i == prev_i) begin
         cls_o = ClsHold;
      end else if (q_i == inc) begin
         cls_o  = ClsUp;
         wrap_o = (prev_i == {WIDTH{1'b1}});
      end else if (q_i == dec) begin
         cls_o  = ClsDn;
         wrap_o = (prev_i == {WIDTH{1'b0}});
      end
   end

endmodule

// File: rtl/count_dir_decoder.sv
// Recovers the up/down mode of an observed counter stream, validates every step
// and locks onto a direction after LOCK_CNT consistent steps.
module count_dir_decoder
   import count_dir_decoder_pkg::*;
#(
   parameter int unsigned WIDTH     = 3,
   parameter int unsigned LOCK_CNT  = 4,
   parameter int unsigned ERR_CNT_W = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic [WIDTH-1:0]     q_in,
   input  logic                 q_valid,
   output logic                 m_out,
   output logic                 dir_valid,
   output logic                 step,
   output logic                 hold,
   output logic                 wrap,
   output logic                 err,
   output logic [ERR_CNT_W-1:0] err_count
);

   localparam logic [RUN_W-1:0]     LockCnt = RUN_W'(LOCK_CNT);
   localparam logic [RUN_W-1:0]     RunOne  = RUN_W'(1);
   localparam logic [ERR_CNT_W-1:0] ErrOne  = {{(ERR_CNT_W-1){1'b0}}, 1'b1};

   state_e               state_q;
   logic [WIDTH-1:0]     prev_q;
   logic [RUN_W-1:0]     run_q;
   logic                 dir_q;
   logic                 m_q;
   logic                 dir_valid_q;
   logic                 step_q;
   logic                 hold_q;
   logic                 wrap_q;
   logic                 err_q;
   logic [ERR_CNT_W-1:0] err_cnt_q;

   step_cls_e            cls;
   logic                 cls_wrap;
   logic                 cls_dir;
   logic [RUN_W-1:0]     acq_run_d;
   logic [ERR_CNT_W-1:0] err_cnt_d;

   count_step_classify #(
      .WIDTH (WIDTH)
   ) u_classify (
      .prev_i (prev_q),
      .q_i    (q_in),
      .cls_o  (cls),
      .wrap_o (cls_wrap)
   );

   // Direction of a legal step, run-length update in ACQ and saturating error count
   always_comb begin
      cls_dir = (cls == ClsUp) ? MODE_UP : MODE_DN;
      if (run_q == '0 || cls_dir == dir_q) begin
         acq_run_d = run_q + RunOne;
      end else begin
         acq_run_d = RunOne;
      end
      err_cnt_d = (err_cnt_q == {ERR_CNT_W{1'b1}}) ? err_cnt_q : err_cnt_q + ErrOne;
   end

   // FSM with registered outputs; pulses clear every cycle unless re-asserted
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q     <= StIdle;
         prev_q      <= '0;
         run_q       <= '0;
         dir_q       <= MODE_UP;
         m_q         <= MODE_UP;
         dir_valid_q <= 1'b0;
         step_q      <= 1'b0;
         hold_q      <= 1'b0;
         wrap_q      <= 1'b0;
         err_q       <= 1'b0;
         err_cnt_q   <= '0;
      end else begin
         step_q <= 1'b0;
         hold_q <= 1'b0;
         wrap_q <= 1'b0;
         err_q  <= 1'b0;
         if (q_valid) begin
            prev_q <= q_in;
            unique case (state_q)
               StIdle: begin
                  state_q <= StAcq;
               end
               StAcq: begin
                  unique case (cls)
                     ClsUp, ClsDn: begin
                        step_q <= 1'b1;
                        wrap_q <= cls_wrap;
                        dir_q  <= cls_dir;
                        run_q  <= acq_run_d;
                        if (acq_run_d == LockCnt) begin
                           state_q     <= StLocked;
                           m_q         <= cls_dir;
                           dir_valid_q <= 1'b1;
                        end
                     end
                     ClsHold: begin
                        hold_q <= 1'b1;
                     end
                     ClsIllegal: begin
                        run_q     <= '0;
                        err_q     <= 1'b1;
                        err_cnt_q <= err_cnt_d;
                     end
                  endcase
               end
               StLocked: begin
                  unique case (cls)
                     ClsUp, ClsDn: begin
                        step_q <= 1'b1;
                        wrap_q <= cls_wrap;
                        // Reversal drops the lock but m_out keeps the old mode
                        if (cls_dir != dir_q) begin
                           state_q     <= StAcq;
                           dir_q       <= cls_dir;
                           run_q       <= RunOne;
                           dir_valid_q <= 1'b0;
                        end
                     end
                     ClsHold: begin
                        hold_q <= 1'b1;
                     end
                     ClsIllegal: begin
                        state_q     <= StAcq;
                        run_q       <= '0;
                        dir_valid_q <= 1'b0;
                        err_q       <= 1'b1;
                        err_cnt_q   <= err_cnt_d;
                     end
                  endcase
               end
               default: begin
                  state_q <= StIdle;
               end
            endcase
         end
      end
   end

   assign m_out     = m_q;
   assign dir_valid = dir_valid_q;
   assign step      = step_q;
   assign hold      = hold_q;
   assign wrap      = wrap_q;
   assign err       = err_q;
   assign err_count = err_cnt_q;

endmodule

// File: tb/tb_count_dir_decoder.sv
// Scoreboard bench for count_dir_decoder: stimulus pushes expected output vectors,
// a monitor pops and compares them one cycle later.
module tb_count_dir_decoder;

   typedef struct {
      logic [7:0] v;
      string      nm;
   } exp_t;

   // Output vector layout: {m_out, dir_valid, step, hold, wrap, err, err_count[1:0]}
   localparam logic [7:0] RstVec = 8'b1_0_0_0_0_0_00;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic [2:0] q_in = 3'd0;
   logic       q_valid = 1'b0;
   logic       m_out;
   logic       dir_valid;
   logic       step;
   logic       hold;
   logic       wrap;
   logic       err;
   logic [1:0] err_count;
   logic [7:0] act;

   int checks = 0;
   int failures = 0;
   exp_t sb[$];

   count_dir_decoder #(
      .WIDTH     (3),
      .LOCK_CNT  (4),
      .ERR_CNT_W (2)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .q_in      (q_in),
      .q_valid   (q_valid),
      .m_out     (m_out),
      .dir_valid (dir_valid),
      .step      (step),
      .hold      (hold),
      .wrap      (wrap),
      .err       (err),
      .err_count (err_count)
   );

   assign act = {m_out, dir_valid, step, hold, wrap, err, err_count};

   always #5 clk = ~clk;

   task automatic chk(input string nm, input logic [7:0] a, input logic [7:0] e);
      checks++;
      if (a !== e) begin
         failures++;
         $display("FAIL %s: got {m,dv,st,ho,wr,er,ec}=%b expected %b", nm, a, e);
      end
   endtask

   // Drive one input cycle and queue the output vector expected after the next edge
   task automatic smp(input logic v, input logic [2:0] q, input logic [7:0] e,
                      input string nm);
      exp_t x;
      @(negedge clk);
      q_valid = v;
      q_in    = q;
      x.v     = e;
      x.nm    = nm;
      sb.push_back(x);
   endtask

   task automatic rst_pulse(input string nm);
      @(negedge clk);
      q_valid = 1'b0;
      rst     = 1'b0;
      #2;
      chk(nm, act, RstVec);
      @(negedge clk);
      rst = 1'b1;
   endtask

   // Monitor: every cycle has an output; compare it if an expectation is pending
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #1;
         if (sb.size() > 0) begin
            e = sb.pop_front();
            chk(e.nm, act, e.v);
         end
      end
   end

   initial begin
      #2;
      rst_pulse("reset_init");

      // Up sweep
      smp(1, 3'd5, 8'b1_0_0_0_0_0_00, "up_first");
      smp(1, 3'd6, 8'b1_0_1_0_0_0_00, "up_s2");
      smp(1, 3'd7, 8'b1_0_1_0_0_0_00, "up_s3");
      smp(1, 3'd0, 8'b1_0_1_0_1_0_00, "up_wrap");
      smp(1, 3'd1, 8'b1_1_1_0_0_0_00, "up_lock");
      smp(0, 3'd5, 8'b1_1_0_0_0_0_00, "up_gap");

      // Down sweep
      rst_pulse("reset_dn");
      smp(1, 3'd2, 8'b1_0_0_0_0_0_00, "dn_first");
      smp(1, 3'd1, 8'b1_0_1_0_0_0_00, "dn_s2");
      smp(1, 3'd0, 8'b1_0_1_0_0_0_00, "dn_s3");
      smp(1, 3'd7, 8'b1_0_1_0_1_0_00, "dn_wrap");
      smp(1, 3'd6, 8'b0_1_1_0_0_0_00, "dn_lock");

      // Direction flip inside ACQ restarts the run at 1
      rst_pulse("reset_flip");
      smp(1, 3'd0, 8'b1_0_0_0_0_0_00, "flip_first");
      smp(1, 3'd1, 8'b1_0_1_0_0_0_00, "flip_up1");
      smp(1, 3'd2, 8'b1_0_1_0_0_0_00, "flip_up2");
      smp(1, 3'd1, 8'b1_0_1_0_0_0_00, "flip_dn1");
      smp(1, 3'd0, 8'b1_0_1_0_0_0_00, "flip_dn2");
      smp(1, 3'd7, 8'b1_0_1_0_1_0_00, "flip_dn3");
      smp(1, 3'd6, 8'b0_1_1_0_0_0_00, "flip_lock");

      // Hold and gaps while locked up at 3
      rst_pulse("reset_hold");
      smp(1, 3'd7, 8'b1_0_0_0_0_0_00, "hg_first");
      smp(1, 3'd0, 8'b1_0_1_0_1_0_00, "hg_wrap");
      smp(1, 3'd1, 8'b1_0_1_0_0_0_00, "hg_s3");
      smp(1, 3'd2, 8'b1_0_1_0_0_0_00, "hg_s4");
      smp(1, 3'd3, 8'b1_1_1_0_0_0_00, "hg_lock");
      smp(0, 3'd5, 8'b1_1_0_0_0_0_00, "hg_gap1");
      smp(1, 3'd3, 8'b1_1_0_1_0_0_00, "hg_hold1");
      smp(0, 3'd6, 8'b1_1_0_0_0_0_00, "hg_gap2");
      smp(1, 3'd3, 8'b1_1_0_1_0_0_00, "hg_hold2");
      smp(0, 3'd1, 8'b1_1_0_0_0_0_00, "hg_gap3");

      // Illegal jump while locked at 3, then relock up from prev=6
      smp(1, 3'd6, 8'b1_0_0_0_0_1_01, "ill_jump");
      smp(1, 3'd7, 8'b1_0_1_0_0_0_01, "ill_s1");
      smp(1, 3'd0, 8'b1_0_1_0_1_0_01, "ill_s2");
      smp(1, 3'd1, 8'b1_0_1_0_0_0_01, "ill_s3");
      smp(1, 3'd2, 8'b1_1_1_0_0_0_01, "ill_relock");

      // Reversal from locked up at 4
      smp(1, 3'd3, 8'b1_1_1_0_0_0_01, "rev_to3");
      smp(1, 3'd4, 8'b1_1_1_0_0_0_01, "rev_to4");
      smp(1, 3'd3, 8'b1_0_1_0_0_0_01, "rev_drop");
      smp(1, 3'd2, 8'b1_0_1_0_0_0_01, "rev_dn2");
      smp(1, 3'd1, 8'b1_0_1_0_0_0_01, "rev_dn3");
      smp(1, 3'd0, 8'b0_1_1_0_0_0_01, "rev_lock");

      // Error counter saturation, then hold and step in ACQ
      smp(1, 3'd4, 8'b0_0_0_0_0_1_10, "sat_e2");
      smp(1, 3'd1, 8'b0_0_0_0_0_1_11, "sat_e3");
      smp(1, 3'd5, 8'b0_0_0_0_0_1_11, "sat_e4");
      smp(1, 3'd2, 8'b0_0_0_0_0_1_11, "sat_e5");
      smp(1, 3'd6, 8'b0_0_0_0_0_1_11, "sat_e6");
      smp(1, 3'd6, 8'b0_0_0_1_0_0_11, "sat_acq_hold");
      smp(1, 3'd7, 8'b0_0_1_0_0_0_11, "sat_acq_up");

      // Asynchronous reset mid-stream, checked before the next clock edge
      @(negedge clk);
      q_valid = 1'b0;
      #1;
      rst = 1'b0;
      #1;
      chk("async_rst", act, RstVec);
      @(negedge clk);
      rst = 1'b1;
      smp(1, 3'd3, 8'b1_0_0_0_0_0_00, "post_rst_first");
      smp(1, 3'd4, 8'b1_0_1_0_0_0_00, "post_rst_step");
      smp(0, 3'd0, 8'b1_0_0_0_0_0_00, "post_rst_gap");

      // Drain the scoreboard within a bounded number of cycles
      for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk);
      if (sb.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL drain: %0d expectations left, required 0", sb.size());
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
